// File: rtl/split_mem.sv
`default_nettype none
// ============================================================================
// split_mem : unified fetch/loader/data memory. The data port splits
//             word-crossing accesses into two word operations.
// Rev 1.0
// ============================================================================
module split_mem #(
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int COL_WIDTH  = 8,
    parameter int NUM_COL    = WORD_WIDTH / COL_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  if_rden,
    input  logic [WORD_WIDTH-1:0] if_addr,
    output logic [WORD_WIDTH-1:0] if_data,
    output logic                  if_valid,
    input  logic                  ld_en,
    input  logic [WORD_WIDTH-1:0] ld_addr,
    input  logic [WORD_WIDTH-1:0] ld_data,
    input  logic                  d_req,
    output logic                  d_ready,
    input  logic                  d_we,
    input  logic [1:0]            d_size,
    input  logic                  d_unsigned,
    input  logic [WORD_WIDTH-1:0] d_addr,
    input  logic [WORD_WIDTH-1:0] d_wdata,
    output logic                  d_rvalid,
    output logic [WORD_WIDTH-1:0] d_rdata,
    output logic                  d_err
);

    localparam int OFF_W = $clog2(NUM_COL);
    localparam int IDX_W = ADDR_WIDTH - OFF_W;
    localparam int DEPTH = 2 ** IDX_W;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SPLIT = 1'b1
    } state_t;

    state_t                  state_q;
    logic                    we_q;
    logic                    uns_q;
    logic [1:0]              size_q;
    logic [OFF_W-1:0]        off_q;
    logic [IDX_W-1:0]        idx_q;
    logic [WORD_WIDTH-1:0]   wdata_q;
    logic [WORD_WIDTH-1:0]   lo_q;
    logic                    rvalid_q;
    logic                    err_q;
    logic [WORD_WIDTH-1:0]   rdata_q;
    logic                    if_valid_q;
    logic [WORD_WIDTH-1:0]   if_data_q;

    logic [WORD_WIDTH-1:0]   mem [DEPTH];

    logic                    in_split;
    logic                    accept;
    logic                    cur_we;
    logic                    cur_uns;
    logic [1:0]              cur_size;
    logic [OFF_W-1:0]        cur_off;
    logic [IDX_W-1:0]        cur_idx;
    logic [WORD_WIDTH-1:0]   cur_wdata;
    logic [WORD_WIDTH-1:0]   rd_word;
    logic                    reserved;
    logic                    crossing;
    int                      nbytes;
    logic [2*WORD_WIDTH-1:0] pair;
    logic [WORD_WIDTH-1:0]   load_raw;
    logic [WORD_WIDTH-1:0]   load_ext;
    logic [NUM_COL-1:0]      lane_be;
    logic [WORD_WIDTH-1:0]   lane_word;
    logic                    mem_op;
    logic                    wr_en;
    logic [IDX_W-1:0]        wr_idx;
    logic [NUM_COL-1:0]      wr_be;
    logic [WORD_WIDTH-1:0]   wr_word;
    logic                    unused_addr_bits;

    assign d_ready  = reset_n & ~ld_en & (state_q == S_IDLE);
    assign accept   = d_req & d_ready;
    assign in_split = (state_q == S_SPLIT);

    // In SPLIT the request comes from the registered copy and targets the next word.
    assign cur_we    = in_split ? we_q    : d_we;
    assign cur_uns   = in_split ? uns_q   : d_unsigned;
    assign cur_size  = in_split ? size_q  : d_size;
    assign cur_off   = in_split ? off_q   : d_addr[OFF_W-1:0];
    assign cur_idx   = in_split ? idx_q + IDX_W'(1) : d_addr[ADDR_WIDTH-1:OFF_W];
    assign cur_wdata = in_split ? wdata_q : d_wdata;
    assign rd_word   = mem[cur_idx];
    assign reserved  = (cur_size == 2'b11);

    always_comb begin
        case (cur_size)
            2'b00:   nbytes = 1;
            2'b01:   nbytes = 2;
            2'b10:   nbytes = 4;
            default: nbytes = 0;
        endcase
        crossing = ((int'(cur_off) + nbytes) > NUM_COL);
    end

    // Bytes are merged from the captured low word and the current high word.
    assign pair     = in_split ? {rd_word, lo_q} : {{WORD_WIDTH{1'b0}}, rd_word};
    assign load_raw = WORD_WIDTH'(pair >> (int'(cur_off) * COL_WIDTH));

    always_comb begin
        case (cur_size)
            2'b00:   load_ext = {{(WORD_WIDTH-COL_WIDTH){~cur_uns & load_raw[COL_WIDTH-1]}},
                                 load_raw[COL_WIDTH-1:0]};
            2'b01:   load_ext = {{(WORD_WIDTH-2*COL_WIDTH){~cur_uns & load_raw[2*COL_WIDTH-1]}},
                                 load_raw[2*COL_WIDTH-1:0]};
            default: load_ext = load_raw;
        endcase
    end

    always_comb begin
        int j;
        j         = 0;
        lane_be   = '0;
        lane_word = '0;
        for (int k = 0; k < NUM_COL; k++) begin
            j = k + (in_split ? NUM_COL : 0) - int'(cur_off);
            if (j >= 0 && j < nbytes) begin
                lane_be[k] = 1'b1;
                lane_word[k*COL_WIDTH +: COL_WIDTH] = cur_wdata[j*COL_WIDTH +: COL_WIDTH];
            end
        end
    end

    assign mem_op  = reset_n & ~ld_en & (in_split | (accept & ~reserved));
    assign wr_en   = reset_n & (ld_en | (mem_op & cur_we));
    assign wr_idx  = ld_en ? ld_addr[ADDR_WIDTH-1:OFF_W] : cur_idx;
    assign wr_be   = ld_en ? {NUM_COL{1'b1}} : lane_be;
    assign wr_word = ld_en ? ld_data : lane_word;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < NUM_COL; k++) begin
                if (wr_be[k]) begin
                    mem[wr_idx][k*COL_WIDTH +: COL_WIDTH] <= wr_word[k*COL_WIDTH +: COL_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            rvalid_q   <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            if_valid_q <= 1'b0;
            if_data_q  <= '0;
        end else begin
            if_valid_q <= if_rden;
            if (if_rden) begin
                if_data_q <= mem[if_addr[ADDR_WIDTH-1:OFF_W]];
            end
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        we_q    <= d_we;
                        uns_q   <= d_unsigned;
                        size_q  <= d_size;
                        off_q   <= cur_off;
                        idx_q   <= cur_idx;
                        wdata_q <= d_wdata;
                        if (reserved) begin
                            rvalid_q <= 1'b1;
                            err_q    <= 1'b1;
                        end else if (crossing) begin
                            state_q <= S_SPLIT;
                            lo_q    <= rd_word;
                        end else begin
                            rvalid_q <= 1'b1;
                            rdata_q  <= d_we ? '0 : load_ext;
                        end
                    end
                end
                S_SPLIT: begin
                    if (!ld_en) begin
                        state_q  <= S_IDLE;
                        rvalid_q <= 1'b1;
                        rdata_q  <= we_q ? '0 : load_ext;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign d_rvalid = rvalid_q;
    assign d_err    = err_q;
    assign d_rdata  = rdata_q;
    assign if_valid = if_valid_q;
    assign if_data  = if_data_q;

    assign unused_addr_bits = ^{if_addr[WORD_WIDTH-1:ADDR_WIDTH], if_addr[OFF_W-1:0],
                                ld_addr[WORD_WIDTH-1:ADDR_WIDTH], ld_addr[OFF_W-1:0],
                                d_addr[WORD_WIDTH-1:ADDR_WIDTH]};

endmodule
`default_nettype wire

// File: tb/tb_split_mem.sv
`default_nettype none
// ============================================================================
// tb_split_mem : directed scoreboard bench for split_mem.
// Rev 1.0
// ============================================================================
module tb_split_mem;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        if_rden;
    logic [31:0] if_addr;
    logic [31:0] if_data;
    logic        if_valid;
    logic        ld_en;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        d_req;
    logic        d_ready;
    logic        d_we;
    logic [1:0]  d_size;
    logic        d_unsigned;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   acc_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    split_mem #(.WORD_WIDTH(32), .ADDR_WIDTH(12), .COL_WIDTH(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .if_rden(if_rden), .if_addr(if_addr), .if_data(if_data), .if_valid(if_valid),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .d_req(d_req), .d_ready(d_ready), .d_we(d_we), .d_size(d_size),
        .d_unsigned(d_unsigned), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic ld_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = addr; ld_data = data;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    // Drive one request, wait for the accept edge, and record its expectation.
    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] edata, input logic eerr, input int elat,
                         input bit push);
        int n;
        @(negedge clk);
        d_we = we; d_size = sz; d_unsigned = uns; d_addr = addr; d_wdata = wd; d_req = 1'b1;
        n = 0;
        while (d_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("issue_ready", {31'b0, d_ready}, 32'd1);
        @(posedge clk); #1;
        d_req   = 1'b0;
        acc_cyc = cyc;
        if (push) sb.push_back('{edata, eerr, elat});
    endtask

    task automatic wait_resp(input string tag);
        exp_t e;
        int   n;
        n = 0;
        while (d_rvalid !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        e = sb.pop_front();
        check({tag, "_rvalid"}, {31'b0, d_rvalid}, 32'd1);
        check({tag, "_lat"}, cyc - acc_cyc + 1, e.lat);
        check({tag, "_data"}, d_rdata, e.data);
        check({tag, "_err"}, {31'b0, d_err}, {31'b0, e.err});
    endtask

    task automatic fetch(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        @(negedge clk);
        if_rden = 1'b1; if_addr = addr;
        @(posedge clk); #1;
        if_rden = 1'b0;
        check({tag, "_valid"}, {31'b0, if_valid}, 32'd1);
        check({tag, "_data"}, if_data, exp);
    endtask

    initial begin
        reset_n = 1'b0; if_rden = 1'b0; if_addr = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        d_req = 1'b0; d_we = 1'b0; d_size = 2'b00; d_unsigned = 1'b0; d_addr = '0; d_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'b0, d_ready}, 32'd0);
        check("rst_rvalid", {31'b0, d_rvalid}, 32'd0);
        check("rst_rdata", d_rdata, 32'd0);
        check("rst_ifvalid", {31'b0, if_valid}, 32'd0);
        check("rst_ifdata", if_data, 32'd0);
        reset_n = 1'b1;

        // T1: loader word then word load; d_ready drops while ld_en is high
        @(negedge clk);
        ld_en = 1'b1; ld_addr = 32'h100; ld_data = 32'hDEADBEEF;
        #1;
        check("ld_blocks_ready", {31'b0, d_ready}, 32'd0);
        @(posedge clk); #1;
        ld_en = 1'b0;
        ld_write(32'h104, 32'h0000_0000);
        issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 1, 1'b1);
        wait_resp("t1_word");

        // T2: byte and half loads with both extensions
        issue(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'hFFFFFFDE, 1'b0, 1, 1'b1);
        wait_resp("t2_byte_s");
        issue(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h000000DE, 1'b0, 1, 1'b1);
        wait_resp("t2_byte_u");
        issue(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'hFFFFDEAD, 1'b0, 1, 1'b1);
        wait_resp("t2_half_s");
        issue(1'b0, 2'b01, 1'b1, 32'h100, 32'h0, 32'h0000BEEF, 1'b0, 1, 1'b1);
        wait_resp("t2_half_u");

        // T3: crossing word store, then readback of both words
        issue(1'b1, 2'b10, 1'b0, 32'h102, 32'h11223344, 32'h0, 1'b0, 2, 1'b1);
        check("t3_split_ready", {31'b0, d_ready}, 32'd0);
        wait_resp("t3_store");
        issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h3344BEEF, 1'b0, 1, 1'b1);
        wait_resp("t3_lo_word");
        issue(1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 32'h00001122, 1'b0, 1, 1'b1);
        wait_resp("t3_hi_word");
        issue(1'b0, 2'b00, 1'b1, 32'h105, 32'h0, 32'h00000011, 1'b0, 1, 1'b1);
        wait_resp("t3_byte105");
        issue(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 32'h11223344, 1'b0, 2, 1'b1);
        wait_resp("t3_cross_load");

        // T5: loader holds SPLIT for 3 cycles and rewrites the high word
        issue(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 32'hF00D3344, 1'b0, 5, 1'b1);
        ld_en = 1'b1; ld_addr = 32'h104; ld_data = 32'hCAFEF00D;
        for (int i = 0; i < 3; i++) begin
            check("t5_hold_ready", {31'b0, d_ready}, 32'd0);
            @(posedge clk); #1;
            check("t5_hold_rvalid", {31'b0, d_rvalid}, 32'd0);
        end
        ld_en = 1'b0;
        wait_resp("t5_cross_load");
        issue(1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 32'hCAFEF00D, 1'b0, 1, 1'b1);
        wait_resp("t5_ld_word");

        // T4: half access wrapping from the top byte to byte 0
        issue(1'b1, 2'b01, 1'b0, 32'hFFF, 32'h0000ABCD, 32'h0, 1'b0, 2, 1'b1);
        wait_resp("t4_store");
        issue(1'b0, 2'b00, 1'b1, 32'hFFF, 32'h0, 32'h000000CD, 1'b0, 1, 1'b1);
        wait_resp("t4_byte_fff");
        issue(1'b0, 2'b00, 1'b1, 32'h000, 32'h0, 32'h000000AB, 1'b0, 1, 1'b1);
        wait_resp("t4_byte_000");
        issue(1'b0, 2'b01, 1'b0, 32'hFFF, 32'h0, 32'hFFFFABCD, 1'b0, 2, 1'b1);
        wait_resp("t4_half_load");

        // T6: reset in SPLIT aborts; loader ignored while in reset
        ld_write(32'h204, 32'h0000_0000);
        ld_write(32'h208, 32'h55667788);
        issue(1'b1, 2'b10, 1'b0, 32'h206, 32'hA1B2C3D4, 32'h0, 1'b0, 2, 1'b0);
        reset_n = 1'b0;
        ld_en = 1'b1; ld_addr = 32'h208; ld_data = 32'hBADBAD00;
        @(posedge clk); #1;
        check("t6_rst_rvalid", {31'b0, d_rvalid}, 32'd0);
        check("t6_rst_ready", {31'b0, d_ready}, 32'd0);
        ld_en = 1'b0;
        reset_n = 1'b1;
        #1;
        check("t6_idle_ready", {31'b0, d_ready}, 32'd1);
        @(posedge clk); #1;
        check("t6_no_late_rvalid", {31'b0, d_rvalid}, 32'd0);
        issue(1'b0, 2'b10, 1'b0, 32'h208, 32'h0, 32'h55667788, 1'b0, 1, 1'b1);
        wait_resp("t6_hi_untouched");
        issue(1'b0, 2'b10, 1'b0, 32'h204, 32'h0, 32'hC3D40000, 1'b0, 1, 1'b1);
        wait_resp("t6_lo_written");

        // Fetch port: latency, ignored low bits, hold, read-before-write
        fetch(32'h100, 32'h3344BEEF, "if_100");
        fetch(32'h102, 32'h3344BEEF, "if_102");
        @(posedge clk); #1;
        check("if_idle_valid", {31'b0, if_valid}, 32'd0);
        check("if_idle_hold", if_data, 32'h3344BEEF);
        ld_write(32'h300, 32'h11111111);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = 32'h300; ld_data = 32'h22222222;
        if_rden = 1'b1; if_addr = 32'h300;
        @(posedge clk); #1;
        ld_en = 1'b0; if_rden = 1'b0;
        check("if_rbw_data", if_data, 32'h11111111);
        fetch(32'h300, 32'h22222222, "if_after_wr");

        // Reserved size: error response, no memory access
        issue(1'b1, 2'b11, 1'b0, 32'h100, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 1'b1);
        wait_resp("rsv_store");
        issue(1'b0, 2'b11, 1'b0, 32'h102, 32'h0, 32'h0, 1'b1, 1, 1'b1);
        wait_resp("rsv_load");
        issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h3344BEEF, 1'b0, 1, 1'b1);
        wait_resp("rsv_no_write");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
